hazard_ctrl: RTL and testbench

- Parametrised pipeline hazard controller for the 5-stage MIPS core; successor to the single-cycle combinational load-use detector.
- Detects load-use hazards and holds IF/ID for a configurable number of bubble cycles via a small FSM.
- Handles taken-branch flushes and excludes writes to register $0.
- Keeps a saturating stall-cycle performance counter.
- Sits between the ID stage and the IF/ID, ID/EX pipeline registers and the PC register.

---
 rtl/hazard_ctrl_if.sv | 29 ++
 rtl/hazard_ctrl.sv | 93 +++++++++
 tb/tb_hazard_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// ID-stage hazard bus: load/operand info from the pipeline in, stall/flush controls back out.
interface hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic              mem_read_ex;
    logic [REG_AW-1:0] rt_ex;
    logic [REG_AW-1:0] rs_id;
    logic [REG_AW-1:0] rt_id;
    logic              uses_rs_id;
    logic              uses_rt_id;
    logic              branch_taken;
    logic              pc_write;
    logic              if_id_write;
    logic              id_ex_bubble;
    logic              if_id_flush;
    logic              stall_active;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output mem_read_ex, rt_ex, rs_id, rt_id, uses_rs_id, uses_rt_id, branch_taken,
        input  pc_write, if_id_write, id_ex_bubble, if_id_flush, stall_active, stall_cnt
    );

    modport slave (
        input  mem_read_ex, rt_ex, rs_id, rt_id, uses_rs_id, uses_rt_id, branch_taken,
        output pc_write, if_id_write, id_ex_bubble, if_id_flush, stall_active, stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Load-use hazard controller: holds IF/ID for LOAD_LAT bubble cycles per hazard,
// flushes on taken branches and keeps a saturating stall-cycle counter.
module hazard_ctrl #(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    hazard_ctrl_if.slave bus
);

    if (LOAD_LAT < 1 || LOAD_LAT > 7) begin : gBadLoadLat
        $error("hazard_ctrl: LOAD_LAT must be in 1..7");
    end

    typedef enum logic {IDLE, HOLD} stateT;

    localparam logic [REG_AW-1:0] zeroReg = '0;
    localparam logic [2:0]        holdStart = 3'(LOAD_LAT - 1);

    stateT            state;
    logic [2:0]       rem;
    logic [CNT_W-1:0] stallCnt;
    logic             haz;
    logic             stallNow;

    assign haz = bus.mem_read_ex && (bus.rt_ex != zeroReg) &&
                 ((bus.uses_rs_id && (bus.rs_id == bus.rt_ex)) ||
                  (bus.uses_rt_id && (bus.rt_id == bus.rt_ex)));

    // Reset forces free-running outputs; a taken branch beats any stall request.
    always_comb begin
        bus.pc_write     = 1'b1;
        bus.if_id_write  = 1'b1;
        bus.id_ex_bubble = 1'b0;
        bus.if_id_flush  = 1'b0;
        stallNow         = 1'b0;
        if (rst_n) begin
            if (bus.branch_taken) begin
                bus.if_id_flush  = 1'b1;
                bus.id_ex_bubble = 1'b1;
            end else if (state == HOLD || haz) begin
                bus.pc_write     = 1'b0;
                bus.if_id_write  = 1'b0;
                bus.id_ex_bubble = 1'b1;
                stallNow         = 1'b1;
            end
        end
    end

    assign bus.stall_active = stallNow;
    assign bus.stall_cnt    = stallCnt;

    // The hazard cycle itself is the first bubble; HOLD supplies the remaining LOAD_LAT-1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            rem      <= 3'd0;
            stallCnt <= '0;
        end else begin
            if (stallNow && (stallCnt != '1)) begin
                stallCnt <= stallCnt + CNT_W'(1);
            end
            if (bus.branch_taken) begin
                state <= IDLE;
                rem   <= 3'd0;
            end else begin
                case (state)
                    IDLE: begin
                        if (haz && (LOAD_LAT > 1)) begin
                            state <= HOLD;
                            rem   <= holdStart;
                        end
                    end
                    HOLD: begin
                        if (rem == 3'd1) begin
                            state <= IDLE;
                            rem   <= 3'd0;
                        end else begin
                            rem <= rem - 3'd1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        rem   <= 3'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (LOAD_LAT=1/CNT_W=4 and LOAD_LAT=3/CNT_W=16)
// share one stimulus stream and are checked against a cycle model through a queue.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rstN;
    logic       memReadEx;
    logic [4:0] rtEx, rsId, rtId;
    logic       usesRsId, usesRtId, branchTaken;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        pc;
        logic        ifid;
        logic        bub;
        logic        flush;
        logic        stall;
        logic [15:0] cnt;
    } expT;

    expT expQ[$];

    int   latK[2]    = '{1, 3};
    int   cntMaxK[2] = '{15, 65535};
    int   mRem[2]    = '{0, 0};
    int   mCnt[2]    = '{0, 0};
    logic stallK[2];
    logic curHaz;

    hazard_ctrl_if #(.REG_AW(5), .CNT_W(4))  ifA ();
    hazard_ctrl_if #(.REG_AW(5), .CNT_W(16)) ifB ();

    assign ifA.mem_read_ex  = memReadEx;
    assign ifA.rt_ex        = rtEx;
    assign ifA.rs_id        = rsId;
    assign ifA.rt_id        = rtId;
    assign ifA.uses_rs_id   = usesRsId;
    assign ifA.uses_rt_id   = usesRtId;
    assign ifA.branch_taken = branchTaken;
    assign ifB.mem_read_ex  = memReadEx;
    assign ifB.rt_ex        = rtEx;
    assign ifB.rs_id        = rsId;
    assign ifB.rt_id        = rtId;
    assign ifB.uses_rs_id   = usesRsId;
    assign ifB.uses_rt_id   = usesRtId;
    assign ifB.branch_taken = branchTaken;

    hazard_ctrl #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(4)) dutA (
        .clk   (clk),
        .rst_n (rstN),
        .bus   (ifA.slave)
    );

    hazard_ctrl #(.REG_AW(5), .LOAD_LAT(3), .CNT_W(16)) dutB (
        .clk   (clk),
        .rst_n (rstN),
        .bus   (ifB.slave)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Drive one cycle of inputs and queue what each instance should show for it.
    task automatic applyStimulus(input logic r, input logic mr, input logic [4:0] rte,
                                 input logic [4:0] rsi, input logic [4:0] rti,
                                 input logic urs, input logic urt, input logic bt);
        expT e;
        rstN = r; memReadEx = mr; rtEx = rte; rsId = rsi; rtId = rti;
        usesRsId = urs; usesRtId = urt; branchTaken = bt;
        curHaz = mr && (rte != 5'd0) && ((urs && rsi == rte) || (urt && rti == rte));
        for (int k = 0; k < 2; k++) begin
            e.pc = 1'b1; e.ifid = 1'b1; e.bub = 1'b0; e.flush = 1'b0; e.stall = 1'b0;
            e.cnt = 16'(mCnt[k]);
            if (r) begin
                if (bt) begin
                    e.bub = 1'b1; e.flush = 1'b1;
                end else if (mRem[k] > 0 || curHaz) begin
                    e.pc = 1'b0; e.ifid = 1'b0; e.bub = 1'b1; e.stall = 1'b1;
                end
            end
            stallK[k] = e.stall;
            expQ.push_back(e);
        end
    endtask

    task automatic compareOne(input string name, input expT e, input logic pc, input logic ifid,
                              input logic bub, input logic flush, input logic stall, input logic [15:0] cnt);
        checkOutput({name, ".pc_write"},     32'(pc),    32'(e.pc));
        checkOutput({name, ".if_id_write"},  32'(ifid),  32'(e.ifid));
        checkOutput({name, ".id_ex_bubble"}, 32'(bub),   32'(e.bub));
        checkOutput({name, ".if_id_flush"},  32'(flush), 32'(e.flush));
        checkOutput({name, ".stall_active"}, 32'(stall), 32'(e.stall));
        checkOutput({name, ".stall_cnt"},    32'(cnt),   32'(e.cnt));
    endtask

    task automatic checkCycle();
        expT e;
        if (expQ.size() < 2) begin
            checkOutput("queue.underflow", 32'(expQ.size()), 32'd2);
            return;
        end
        e = expQ.pop_front();
        compareOne("A", e, ifA.pc_write, ifA.if_id_write, ifA.id_ex_bubble,
                   ifA.if_id_flush, ifA.stall_active, 16'(ifA.stall_cnt));
        e = expQ.pop_front();
        compareOne("B", e, ifB.pc_write, ifB.if_id_write, ifB.id_ex_bubble,
                   ifB.if_id_flush, ifB.stall_active, ifB.stall_cnt);
    endtask

    task automatic stepModel();
        for (int k = 0; k < 2; k++) begin
            if (!rstN) begin
                mRem[k] = 0;
                mCnt[k] = 0;
            end else begin
                if (stallK[k] && mCnt[k] < cntMaxK[k]) mCnt[k]++;
                if (branchTaken)      mRem[k] = 0;
                else if (mRem[k] > 0) mRem[k]--;
                else if (curHaz)      mRem[k] = latK[k] - 1;
            end
        end
    endtask

    task automatic runCycle(input logic r, input logic mr, input logic [4:0] rte,
                            input logic [4:0] rsi, input logic [4:0] rti,
                            input logic urs, input logic urt, input logic bt);
        applyStimulus(r, mr, rte, rsi, rti, urs, urt, bt);
        #1;
        checkCycle();
        @(posedge clk);
        stepModel();
        @(negedge clk);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) runCycle(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic resetCycle();
        runCycle(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        applyStimulus(1'b0, 1'b1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0);
        void'(expQ.pop_front());
        void'(expQ.pop_front());
        @(negedge clk);

        // Reset held during an active hazard, then released with inputs unchanged.
        runCycle(1'b0, 1'b1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0);
        runCycle(1'b0, 1'b1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("release.A.stall_active", 32'(ifA.stall_active), 32'd1);
        checkCycle();
        @(posedge clk); stepModel(); @(negedge clk);
        idleCycles(3);
        resetCycle();

        // Single-cycle rt-match load-use.
        runCycle(1'b1, 1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0);
        idleCycles(3);
        applyStimulus(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("lat1.A.stall_cnt", 32'(ifA.stall_cnt), 32'd1);
        checkOutput("lat3.B.stall_cnt", 32'(ifB.stall_cnt), 32'd3);
        checkCycle();
        @(posedge clk); stepModel(); @(negedge clk);

        // Loads to $0 and unqualified operands never stall.
        runCycle(1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
        runCycle(1'b1, 1'b1, 5'd4, 5'd4, 5'd4, 1'b0, 1'b0, 1'b0);
        resetCycle();

        // rs hazard on r9, then a taken branch aborts the HOLD.
        runCycle(1'b1, 1'b1, 5'd9, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        #1;
        checkOutput("flush.B.if_id_flush", 32'(ifB.if_id_flush), 32'd1);
        checkCycle();
        @(posedge clk); stepModel(); @(negedge clk);
        applyStimulus(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("flush.B.idle_after", 32'(ifB.stall_active), 32'd0);
        checkOutput("flush.B.stall_cnt",  32'(ifB.stall_cnt),    32'd1);
        checkCycle();
        @(posedge clk); stepModel(); @(negedge clk);
        resetCycle();

        // Continuous hazard: the 4-bit counter must saturate.
        for (int i = 0; i < 20; i++) runCycle(1'b1, 1'b1, 5'd7, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("sat.A.stall_cnt", 32'(ifA.stall_cnt), 32'd15);
        checkCycle();
        @(posedge clk); stepModel(); @(negedge clk);
        idleCycles(3);

        // Random mix with small register range to provoke matches.
        for (int i = 0; i < 300; i++) begin
            runCycle(1'($urandom_range(0, 24) != 0), 1'($urandom_range(0, 1)),
                     5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 9) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
